// File: rtl/lc3_writeback_stage.sv
// ---------------------------------------------------------------------------
// lc3_writeback_stage
//
// Writeback stage of an LC-3 style pipeline: holds the 8-entry register file
// (R0-R7) and the condition-code register psr {N,Z,P}, and provides two
// registered read ports.
//
// Ports
//   clock            : single clock, all state changes on the rising edge
//   reset            : synchronous, active-high; clears all state
//   enable_writeback : qualifies a writeback this cycle
//   W_Control        : writeback source select 0=aluout 1=pcout 2=memout
//                      3=illegal (no write, wb_error pulse)
//   aluout/pcout/memout : candidate writeback sources
//   dr               : destination register index
//   sr1/sr2          : read port indices
//   d1/d2            : registered read data, one-cycle latency, with bypass
//                      of a same-edge write
//   psr              : condition codes of the most recent legal write
//   wb_error         : one-cycle pulse after an illegal select was enabled
// ---------------------------------------------------------------------------
module lc3_writeback_stage #(
    parameter int DWIDTH = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_writeback,
    input  logic [1:0]        W_Control,
    input  logic [DWIDTH-1:0] aluout,
    input  logic [DWIDTH-1:0] pcout,
    input  logic [DWIDTH-1:0] memout,
    input  logic [2:0]        dr,
    input  logic [2:0]        sr1,
    input  logic [2:0]        sr2,
    output logic [DWIDTH-1:0] d1,
    output logic [DWIDTH-1:0] d2,
    output logic [2:0]        psr,
    output logic              wb_error
);

    logic [DWIDTH-1:0] regs_q [8];
    logic [DWIDTH-1:0] regs_d [8];
    logic [DWIDTH-1:0] d1_q, d1_d;
    logic [DWIDTH-1:0] d2_q, d2_d;
    logic [2:0]        psr_q, psr_d;
    logic              wb_error_q, wb_error_d;

    logic [DWIDTH-1:0] wr_data;
    logic              wr_en;

    always_comb begin
        wr_data = aluout;
        case (W_Control)
            2'd0:    wr_data = aluout;
            2'd1:    wr_data = pcout;
            2'd2:    wr_data = memout;
            default: wr_data = aluout;
        endcase

        wr_en      = enable_writeback && (W_Control != 2'd3);
        wb_error_d = enable_writeback && (W_Control == 2'd3);

        regs_d = regs_q;
        psr_d  = psr_q;
        if (wr_en) begin
            regs_d[dr] = wr_data;
            if (wr_data[DWIDTH-1])
                psr_d = 3'b100;
            else if (wr_data == '0)
                psr_d = 3'b010;
            else
                psr_d = 3'b001;
        end

        // Reading the post-write image gives the same-edge bypass for free;
        // an illegal select never modifies regs_d, so no bypass occurs then.
        d1_d = regs_d[sr1];
        d2_d = regs_d[sr2];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
            d1_q       <= '0;
            d2_q       <= '0;
            psr_q      <= 3'b000;
            wb_error_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            d1_q       <= d1_d;
            d2_q       <= d2_d;
            psr_q      <= psr_d;
            wb_error_q <= wb_error_d;
        end
    end

    assign d1       = d1_q;
    assign d2       = d2_q;
    assign psr      = psr_q;
    assign wb_error = wb_error_q;

endmodule

// File: doc/lc3_writeback_stage.md
LC3_WRITEBACK_STAGE -- requirements
Module: lc3_writeback_stage

Interface
REQ-001 SHALL have parameter: DWIDTH, 16, register/data width; only 16 is supported.
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: enable_writeback  input  1  qualifies a writeback this cycle.
REQ-005 SHALL have port: W_Control  input  2  source select: 0=aluout, 1=pcout, 2=memout, 3=illegal.
REQ-006 SHALL have port: aluout  input  DWIDTH  ALU result.
REQ-007 SHALL have port: pcout  input  DWIDTH  PC-relative result.
REQ-008 SHALL have port: memout  input  DWIDTH  memory load data.
REQ-009 SHALL have port: dr  input  3  destination register index.
REQ-010 SHALL have port: sr1  input  3  read port 1 index.
REQ-011 SHALL have port: sr2  input  3  read port 2 index.
REQ-012 SHALL have port: d1  output  DWIDTH  registered read data for sr1.
REQ-013 SHALL have port: d2  output  DWIDTH  registered read data for sr2.
REQ-014 SHALL have port: psr  output  3  condition codes {N,Z,P}.
REQ-015 SHALL have port: wb_error  output  1  one-cycle pulse on illegal W_Control with enable_writeback.

Function
REQ-016 SHALL hold an 8 x DWIDTH register file R0-R7 and a 3-bit psr register.
REQ-017 SHALL, on a clock edge with enable_writeback=1 and W_Control in {0,1,2}, write the selected source into R[dr].
REQ-018 SHALL, on the same edge as REQ-017, set psr to 3'b100 if written value bit15=1, 3'b010 if value=0, else 3'b001.
REQ-019 SHALL leave the register file and psr unchanged when enable_writeback=0.
REQ-020 SHALL, with enable_writeback=1 and W_Control=3, perform no write, leave psr unchanged, and assert wb_error for exactly the next cycle.
REQ-021 SHALL drive wb_error=0 in every cycle not covered by REQ-020.
REQ-022 SHALL update d1/d2 every edge with R[sr1]/R[sr2]: one-cycle read latency, independent of enable_writeback.
REQ-023 SHALL bypass: if a write per REQ-017 occurs on the same edge and dr==sr1 (resp. sr2), d1 (resp. d2) SHALL load the newly written value, not the old contents.
REQ-024 SHALL support sr1==sr2, both ports returning the same value, bypass included.
REQ-025 SHALL treat consecutive-cycle writes to the same dr as last-writer-wins; psr reflects the most recent legal write.
REQ-026 SHALL never write R[dr] when W_Control=3, including when dr equals sr1/sr2 (no bypass applied).
REQ-027 SHALL ignore X-free unselected sources; only the selected source affects state.

Reset
REQ-028 SHALL, on any edge with reset=1, clear R0-R7 to 16'h0000, psr to 3'b000, d1/d2 to 16'h0000, wb_error to 0.
REQ-029 SHALL give reset priority over a simultaneous enable_writeback: no write, no wb_error.
REQ-030 SHALL resume normal operation on the first edge after reset deasserts; reset mid-sequence discards all prior writes.
REQ-031 SHALL keep psr=3'b000 after reset until the first legal write.

Verification
REQ-032 SHALL cover: reset then sr1=0,sr2=7 -> d1=d2=16'h0000, psr=3'b000, wb_error=0.
REQ-033 SHALL cover: enable=1,W_Control=0,aluout=16'h8001,dr=3 then sr1=3 -> d1=16'h8001, psr=3'b100; W_Control=1,pcout=0,dr=4 -> psr=3'b010; W_Control=2,memout=16'h0005,dr=5 -> psr=3'b001.
REQ-034 SHALL cover bypass: enable=1,W_Control=2,memout=16'h1234,dr=2,sr1=2,sr2=2 same cycle -> d1=d2=16'h1234 next cycle.
REQ-035 SHALL cover illegal select: R6=16'h00AA, enable=1,W_Control=3,dr=6,aluout=16'hFFFF -> R6 stays 16'h00AA, psr unchanged, wb_error=1 for one cycle then 0.
REQ-036 SHALL cover reset priority: reset=1 with enable=1,W_Control=0,aluout=16'h7777,dr=1 -> R1=16'h0000, psr=3'b000 after reset.
REQ-037 SHALL cover enable=0 for 4 cycles with varying sources/dr -> register file and psr unchanged; d1/d2 track sr1/sr2 with one-cycle latency.
